wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-precision adder front/back end for the 16-bit kogge_stone_adder (ports A,B,Cin,S,Cout).
//  Accepts a WORDS-word operand pair one 16-bit word per transfer, least-significant word first.
//  Feeds each word pair to one internal kogge_stone_adder instance, chaining the carry between words.
//  Registers and returns the sum words in order. Produces an N*16-bit add using one 16-bit adder.
// PARAMETERS
//  WORDS   4    number of 16-bit words per operand (2..256); total width = 16*WORDS
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous active-high reset
//  start      in   1   begin operation; sampled only in IDLE
//  Cin        in   1   carry into word 0; captured with start
//  in_valid   in   1   A_word/B_word valid
//  in_ready   out  1   sequencer accepts a word pair this cycle
//  A_word     in   16  operand A word
//  B_word     in   16  operand B word
//  out_valid  out  1   S_word valid
//  out_ready  in   1   consumer accepts S_word
//  S_word     out  16  registered sum word
//  out_last   out  1   S_word is most-significant word
//  Cout       out  1   final carry; valid from done pulse until next start
//  ovf        out  1   signed overflow of full-width result (see CONFIGURATION)
//  busy       out  1   high in any state except IDLE
//  done       out  1   one-cycle pulse when last sum word is consumed
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, out_last, S_word, Cout, ovf, busy, done all 0; word count=0.
//  FSM IDLE -> RUN on start (carry_reg<=Cin, count<=0, Cout<=0, ovf<=0); start ignored outside IDLE.
//  RUN: in_ready = !out_valid || out_ready (single-entry output register, full throughput).
//  Accept = in_valid && in_ready. On accept: S_word<=S(A_word,B_word,carry_reg), carry_reg<=adder Cout,
//   out_valid<=1, out_last<=(count==WORDS-1), count<=count+1.
//  Latency: accept at cycle n -> out_valid with S_word at n+1.
//  Output handshake: S_word/out_last held stable while out_valid && !out_ready; out_valid drops when
//   consumed and no new accept in the same cycle. Simultaneous consume+accept: register reloaded, out_valid stays 1.
//  RUN -> DRAIN after accept with count==WORDS-1; in_ready=0 in DRAIN.
//  DRAIN: when last word consumed: Cout<=carry_reg, done=1 for one cycle, state->IDLE.
//  in_valid while in_ready=0 or in IDLE has no effect; words are never dropped or duplicated.
//  Carry chaining: carry of word k feeds Cin of word k+1 only; no carry between operations.
//  rst mid-operation: returns to reset state next cycle; partial results discarded, no done pulse.
//  Cout and ovf hold their value from done until next accepted start.
// CONFIGURATION
//  OVERFLOW_FLAG_EN defined: on the last-word accept, ovf_next=(A_word[15]==B_word[15]) &&
//   (S[15]!=A_word[15]); latched to ovf together with Cout at done.
//  OVERFLOW_FLAG_EN undefined: ovf tied to 0; no overflow logic synthesised.
// TESTING  (WORDS=4)
//  Reset: rst=1 2 cycles mid-RUN -> next cycle all outputs 0, busy=0, no done pulse.
//  Zero: start Cin=0, 4x A=0x0000 B=0x0000 -> S_word 0x0000 x4, out_last on 4th, done, Cout=0.
//  Ripple: Cin=1, 4x A=0xFFFF B=0x0000 -> S_word 0x0000 x4, Cout=1.
//  Small: Cin=1, word0 A=0x0005 B=0x0003, rest 0 -> S_word 0x0009,0,0,0; Cout=0.
//  Backpressure: out_ready=0 3 cycles after word0 -> in_ready=0, S_word held, sequence intact after release.
//  Overflow (macro on): word3 A=0x7FFF B=0x0001, lower words 0 -> ovf=1, Cout=0; macro off -> ovf=0.

Source files
------------

// File: rtl/wide_add_sequencer_if.sv
// Word-serial operand/result bus for wide_add_sequencer.
// master drives operands and start; slave returns sum words and status.
interface wide_add_sequencer_if;
  logic        start;
  logic        Cin;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A_word;
  logic [15:0] B_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S_word;
  logic        out_last;
  logic        Cout;
  logic        ovf;
  logic        busy;
  logic        done;

  modport master (
    output start, Cin, in_valid, A_word, B_word, out_ready,
    input  in_ready, out_valid, S_word, out_last, Cout, ovf, busy, done
  );

  modport slave (
    input  start, Cin, in_valid, A_word, B_word, out_ready,
    output in_ready, out_valid, S_word, out_last, Cout, ovf, busy, done
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// WORDS x 16-bit add streamed through one 16-bit Kogge-Stone adder.
// Optional macro OVERFLOW_FLAG_EN adds the signed overflow flag.
module kogge_stone_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;

  // Cin folded into bit 0 generate so the prefix tree yields all carries
  always_comb begin
    g = A & B;
    p = A ^ B;
    g[0] = g[0] | (p[0] & Cin);
    for (int l = 0; l < 4; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & ((p << (1 << l)) | ((16'd1 << (1 << l)) - 16'd1));
    end
    c = {g[14:0], Cin};
    S = (A ^ B) ^ c;
    Cout = g[15];
  end
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  wide_add_sequencer_if.slave bus
);
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0] count;
  logic          carry;
  logic [15:0]   sum;
  logic          co;
  logic [15:0]   s_q;
  logic          valid_q;
  logic          last_q;
  logic          cout_q;
  logic          is_last;
  logic          accept;
  logic          consume;
  logic          in_ready;
  logic          done;

  kogge_stone_adder u_add (
    .A   (bus.A_word),
    .B   (bus.B_word),
    .Cin (carry),
    .S   (sum),
    .Cout(co)
  );

  assign is_last = (count == CW'(WORDS - 1));

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    consume    = valid_q && bus.out_ready;
    unique case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        in_ready = !valid_q || bus.out_ready;
      end
      DRAIN: begin
        if (consume) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    accept = bus.in_valid && in_ready;
    if (accept && is_last) state_next = DRAIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      carry   <= 1'b0;
      s_q     <= 16'h0000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.start) begin
        carry  <= bus.Cin;
        count  <= '0;
        cout_q <= 1'b0;
      end
      if (accept) begin
        s_q     <= sum;
        carry   <= co;
        valid_q <= 1'b1;
        last_q  <= is_last;
        count   <= count + 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
      if (done) cout_q <= carry;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_pend;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_pend <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) ovf_q <= 1'b0;
      if (accept && is_last)
        ovf_pend <= (bus.A_word[15] == bus.B_word[15]) &&
                    (sum[15] != bus.A_word[15]);
      if (done) ovf_q <= ovf_pend;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.S_word    = s_q;
  assign bus.out_last  = last_q;
  assign bus.Cout      = cout_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with WORDS=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_wide_add_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wide_add_sequencer_if bus ();

  wide_add_sequencer #(.WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ovld"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_irdy"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic cin,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] s, input logic co,
                        input logic ov);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_irdy"}, 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.A_word   = a[16*k +: 16];
      bus.B_word   = b[16*k +: 16];
      bus.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("%s_s%0d", tag, k), 32'(bus.S_word),
            32'(s[16*k +: 16]));
      check($sformatf("%s_v%0d", tag, k), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_l%0d", tag, k), 32'(bus.out_last),
            32'(k == 3));
      check($sformatf("%s_d%0d", tag, k), 32'(bus.done), 32'(k == 3));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_idle({tag, "_end"});
    check({tag, "_cout"}, 32'(bus.Cout), 32'(co));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(ov));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.Cin       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A_word    = 16'h0000;
    bus.B_word    = 16'h0000;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("rst");
    check("rst_s", 32'(bus.S_word), 32'd0);
    check("rst_cout", 32'(bus.Cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    rst = 1'b0;

    run_op("zero", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    run_op("ripple", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0,
           1'b1, 1'b0);

    // Cout holds after done; words offered in IDLE are ignored
    bus.A_word   = 16'h1234;
    bus.B_word   = 16'h4321;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("hold_cout", 32'(bus.Cout), 32'd1);
    check_idle("idle_in");
    bus.in_valid = 1'b0;

    // Reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.Cin   = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.A_word   = 16'h00FF;
    bus.B_word   = 16'h0001;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle($sformatf("mid_rst%0d", i));
      check($sformatf("mid_rst%0d_s", i), 32'(bus.S_word), 32'd0);
      check($sformatf("mid_rst%0d_c", i), 32'(bus.Cout), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst");

    run_op("small", 1'b1, 64'h0000_0000_0000_0005,
           64'h0000_0000_0000_0003, 64'h0000_0000_0000_0009,
           1'b0, 1'b0);

    // Backpressure: stall 3 cycles after word0, carry must survive
    @(negedge clk);
    bus.start = 1'b1;
    bus.Cin   = 1'b0;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.A_word   = 16'h8000;
    bus.B_word   = 16'h8000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("bp_s0", 32'(bus.S_word), 32'h0000);
    bus.out_ready = 1'b0;
    bus.A_word    = 16'h0001;
    bus.B_word    = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_s%0d", i), 32'(bus.S_word), 32'h0000);
      check($sformatf("bp_hold_v%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold_r%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_s1", 32'(bus.S_word), 32'h0002);
    bus.A_word = 16'hFFFF;
    bus.B_word = 16'hFFFF;
    @(negedge clk);
    check("bp_s2", 32'(bus.S_word), 32'hFFFE);
    bus.A_word = 16'h1234;
    bus.B_word = 16'h1111;
    @(negedge clk);
    check("bp_s3", 32'(bus.S_word), 32'h2346);
    check("bp_l3", 32'(bus.out_last), 32'd1);
    check("bp_done", 32'(bus.done), 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_idle("bp_end");
    check("bp_cout", 32'(bus.Cout), 32'd0);

    run_op("ovf", 1'b0, 64'h7FFF_0000_0000_0000,
           64'h0001_0000_0000_0000, 64'h8000_0000_0000_0000,
           1'b0, OVF_EXP);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
